mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 20 ++
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential signed multiply/divide unit.
//   DEFAULT_WIDTH  operand width used when the unit is not parameterised
//   OP_MULT/OP_DIV encoding of the Op input
//   state_t        controller state encoding
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Sequential signed multiply / divide unit, one result bit per cycle.
//
// Ports:
//   Clk      system clock, rising edge
//   Reset    synchronous active-low reset
//   Start    begin an operation (accepted only in IDLE)
//   Op       0 = signed multiply, 1 = signed divide
//   A, B     multiplicand/dividend and multiplier/divisor
//   Hi, Lo   MULT: product upper/lower half; DIV: remainder/quotient
//   Busy     high whenever the unit is not idle
//   Done     one-cycle completion pulse
//   DivZero  sticky divide-by-zero flag, cleared by the next accepted Start
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for Start
// MULT   | unsigned shift-add on operand magnitudes, WIDTH iterations
// DIV    | unsigned restoring division on magnitudes, WIDTH iterations
// FIX    | apply sign correction and load Hi/Lo
// DONE   | one-cycle completion, Done high
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] ITER = CW'(WIDTH);

  state_t          state;
  logic [CW-1:0]   count;
  logic            op_q;
  logic            sign_a;
  logic            sign_b;
  // work_hi is one bit wider to hold the adder carry (MULT) and the
  // trial-subtraction borrow (DIV).
  logic [WIDTH:0]  work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] operand;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude in WIDTH bits.
    abs_a     = A[WIDTH-1] ? -A : A;
    abs_b     = B[WIDTH-1] ? -B : B;
    add_sum   = work_hi + (work_lo[0] ? {1'b0, operand} : '0);
    div_shift = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    prod      = {work_hi[WIDTH-1:0], work_lo};
    prod_fix  = (sign_a ^ sign_b) ? -prod : prod;
    quot_fix  = (sign_a ^ sign_b) ? -work_lo : work_lo;
    rem_fix   = sign_a ? -work_hi[WIDTH-1:0] : work_hi[WIDTH-1:0];
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= S_IDLE;
      count   <= '0;
      op_q    <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      work_hi <= '0;
      work_lo <= '0;
      operand <= '0;
      Hi      <= '0;
      Lo      <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q    <= Op;
            sign_a  <= A[WIDTH-1];
            sign_b  <= B[WIDTH-1];
            Busy    <= 1'b1;
            if (Op == OP_DIV && B == '0) begin
              DivZero <= 1'b1;
              Done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              DivZero <= 1'b0;
              count   <= ITER;
              work_hi <= '0;
              work_lo <= abs_a;
              operand <= abs_b;
              state   <= (Op == OP_DIV) ? S_DIV : S_MULT;
            end
          end
        end
        S_MULT: begin
          // Shift {sum, multiplier} right: product bits enter work_lo from the top.
          work_hi <= {1'b0, add_sum[WIDTH:1]};
          work_lo <= {add_sum[0], work_lo[WIDTH-1:1]};
          count   <= count - 1'b1;
          if (count == CW'(1)) state <= S_FIX;
        end
        S_DIV: begin
          // Borrow set means the trial subtraction failed: restore.
          if (div_diff[WIDTH]) begin
            work_hi <= div_shift;
            work_lo <= {work_lo[WIDTH-2:0], 1'b0};
          end else begin
            work_hi <= div_diff;
            work_lo <= {work_lo[WIDTH-2:0], 1'b1};
          end
          count <= count - 1'b1;
          if (count == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (op_q == OP_MULT) begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end else begin
            Hi <= rem_fix;
            Lo <= quot_fix;
          end
          Done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
